frame_sequencer: RTL and testbench

- Per-frame controller for the double-buffered sprite pipeline. Runs in the pixel clock domain, between the screen timing (vsync), framebuffer_master (buffer swap/clear) and sprite_driver (draw enable).
- Each frame it performs four steps in order: request a buffer swap, start the back-buffer clear, let sprite_driver drain the sprite queue, then idle until the next frame boundary.
- Tracks frame count, sprites drawn per frame and overruns, i.e. frame boundaries that arrive before drawing finished.

---
 rtl/kule_seq_pkg.sv | 20 ++
 rtl/frame_edge_detect.sv | 25 ++
 rtl/frame_sequencer.sv | 152 +++++++++++++++
 tb/tb_frame_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/kule_seq_pkg.sv
// Shared types and widths for the per-frame sprite pipeline sequencer.
package kule_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SWAP  = 3'd1,
    CLEAR = 3'd2,
    DRAW  = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } seq_state_t;

  localparam int FRAME_CNT_W  = 16;
  localparam int SPRITE_CNT_W = 8;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/frame_edge_detect.sv
// Turns the vsync level into a single-cycle pulse on its assertion edge.
module frame_edge_detect #(
  parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic vsync,
  output logic frame_edge
);

  logic vsync_reg;
  logic active_now;
  logic active_prev;

  // Reset to the deasserted level so a quiet vsync produces no spurious edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) vsync_reg <= VSYNC_ACTIVE_LOW;
    else          vsync_reg <= vsync;
  end

  assign active_now  = vsync ^ VSYNC_ACTIVE_LOW;
  assign active_prev = vsync_reg ^ VSYNC_ACTIVE_LOW;
  assign frame_edge  = active_now & ~active_prev;

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame controller: swap, clear, draw, then idle until the next frame edge.
module frame_sequencer
  import kule_seq_pkg::*;
#(
  parameter int MAX_SPRITES      = 64,
  parameter int CLEAR_TIMEOUT    = 16,
  parameter int VSYNC_ACTIVE_LOW = 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    vsync,
  output logic                    swap_req,
  input  logic                    swap_ack,
  output logic                    clear_start,
  input  logic                    clear_busy,
  output logic                    draw_en,
  input  logic                    driver_busy,
  input  logic                    sprite_done,
  input  logic                    queue_empty,
  output logic [FRAME_CNT_W-1:0]  frame_count,
  output logic [SPRITE_CNT_W-1:0] sprites_drawn,
  output logic                    overrun,
  output logic [7:0]              overrun_count
);

  localparam int TIMER_W = (CLEAR_TIMEOUT > 1) ? $clog2(CLEAR_TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0]      TIMER_LAST = TIMER_W'(CLEAR_TIMEOUT - 1);
  localparam logic [SPRITE_CNT_W-1:0] SPRITE_CAP = SPRITE_CNT_W'(MAX_SPRITES);

  seq_state_t              state_reg;
  logic [TIMER_W-1:0]      clear_timer_reg;
  logic                    busy_seen_reg;
  logic [SPRITE_CNT_W-1:0] sprite_cnt_reg;
  logic [SPRITE_CNT_W-1:0] sprite_cnt_next;
  logic                    frame_edge;
  logic                    draw_done;
  logic                    edge_overrun;

  frame_edge_detect #(
    .VSYNC_ACTIVE_LOW(VSYNC_ACTIVE_LOW != 0)
  ) u_edge (
    .clock      (clock),
    .reset_n    (reset_n),
    .vsync      (vsync),
    .frame_edge (frame_edge)
  );

  // Includes this cycle's completion so a pulse coinciding with an exit is counted.
  assign sprite_cnt_next = (sprite_done && (sprite_cnt_reg < SPRITE_CAP))
                         ? sprite_cnt_reg + 1'b1 : sprite_cnt_reg;
  assign draw_done       = (queue_empty && !driver_busy) || (sprite_cnt_next >= SPRITE_CAP);
  assign edge_overrun    = frame_edge &&
                           ((state_reg == SWAP) || (state_reg == CLEAR) || (state_reg == DRAIN));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      clear_timer_reg <= '0;
      busy_seen_reg   <= 1'b0;
      sprite_cnt_reg  <= '0;
      swap_req        <= 1'b0;
      clear_start     <= 1'b0;
      draw_en         <= 1'b0;
      frame_count     <= '0;
      sprites_drawn   <= '0;
      overrun         <= 1'b0;
      overrun_count   <= '0;
    end else begin
      clear_start <= 1'b0;
      if (edge_overrun) begin
        overrun       <= 1'b1;
        overrun_count <= sat_inc8(overrun_count);
      end
      case (state_reg)
        IDLE: begin
          if (frame_edge) begin
            state_reg      <= SWAP;
            swap_req       <= 1'b1;
            sprite_cnt_reg <= '0;
          end
        end
        SWAP: begin
          if (swap_ack) begin
            state_reg       <= CLEAR;
            swap_req        <= 1'b0;
            clear_start     <= 1'b1;
            frame_count     <= frame_count + 1'b1;
            clear_timer_reg <= '0;
            busy_seen_reg   <= 1'b0;
          end
        end
        CLEAR: begin
          // The timeout only guards the wait for clear_busy to rise.
          if (busy_seen_reg) begin
            if (!clear_busy) begin
              state_reg <= DRAW;
              draw_en   <= 1'b1;
            end
          end else if (clear_busy) begin
            busy_seen_reg <= 1'b1;
          end else if (clear_timer_reg == TIMER_LAST) begin
            state_reg <= DRAW;
            draw_en   <= 1'b1;
          end else begin
            clear_timer_reg <= clear_timer_reg + 1'b1;
          end
        end
        DRAW: begin
          sprite_cnt_reg <= sprite_cnt_next;
          if (draw_done) begin
            draw_en       <= 1'b0;
            sprites_drawn <= sprite_cnt_next;
            if (frame_edge) begin
              state_reg      <= SWAP;
              swap_req       <= 1'b1;
              sprite_cnt_reg <= '0;
            end else begin
              state_reg <= DONE;
            end
          end else if (frame_edge) begin
            overrun       <= 1'b1;
            overrun_count <= sat_inc8(overrun_count);
            draw_en       <= 1'b0;
            state_reg     <= DRAIN;
          end
        end
        DRAIN: begin
          sprite_cnt_reg <= sprite_cnt_next;
          if (!driver_busy) begin
            sprites_drawn  <= sprite_cnt_next;
            state_reg      <= SWAP;
            swap_req       <= 1'b1;
            sprite_cnt_reg <= '0;
          end
        end
        DONE: begin
          if (frame_edge) begin
            state_reg      <= SWAP;
            swap_req       <= 1'b1;
            sprite_cnt_reg <= '0;
          end
        end
        default: begin
          state_reg <= IDLE;
          swap_req  <= 1'b0;
          draw_en   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: handshake timing, clear timeout, caps, overruns, reset.
module tb_frame_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        vsync;
  logic        swap_req;
  logic        swap_ack;
  logic        clear_start;
  logic        clear_busy;
  logic        draw_en;
  logic        driver_busy;
  logic        sprite_done;
  logic        queue_empty;
  logic [15:0] frame_count;
  logic [7:0]  sprites_drawn;
  logic        overrun;
  logic [7:0]  overrun_count;

  int check_count = 0;
  int error_count = 0;

  frame_sequencer dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .vsync         (vsync),
    .swap_req      (swap_req),
    .swap_ack      (swap_ack),
    .clear_start   (clear_start),
    .clear_busy    (clear_busy),
    .draw_en       (draw_en),
    .driver_busy   (driver_busy),
    .sprite_done   (sprite_done),
    .queue_empty   (queue_empty),
    .frame_count   (frame_count),
    .sprites_drawn (sprites_drawn),
    .overrun       (overrun),
    .overrun_count (overrun_count)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Bounded wait for DRAW entry; returns cycles waited.
  task automatic wait_draw(output int n);
    n = 0;
    while (!draw_en && n < 64) begin
      tick();
      n++;
    end
    check_eq("draw_entered", 32'(draw_en), 1);
  endtask

  // Frame edge from DONE, immediate ack, clear never busy.
  task automatic start_frame(input int exp_frames, output int n);
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    check_eq("swap_req_on_edge", 32'(swap_req), 1);
    swap_ack = 1'b1;
    tick();
    swap_ack = 1'b0;
    check_eq("clear_start_pulse", 32'(clear_start), 1);
    check_eq("frame_count", 32'(frame_count), 32'(exp_frames));
    wait_draw(n);
  endtask

  initial begin
    int sr_cycles;
    int n;
    int en_cycles;

    reset_n = 1'b0;
    vsync = 1'b1;
    swap_ack = 1'b0;
    clear_busy = 1'b0;
    driver_busy = 1'b0;
    sprite_done = 1'b0;
    queue_empty = 1'b0;
    repeat (3) tick();
    check_eq("rst_swap_req", 32'(swap_req), 0);
    check_eq("rst_draw_en", 32'(draw_en), 0);
    check_eq("rst_frame_count", 32'(frame_count), 0);
    reset_n = 1'b1;
    tick();
    check_eq("idle_no_swap", 32'(swap_req), 0);

    // 1: swap handshake with ack two cycles after swap_req
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    check_eq("t1_swap_req_rise", 32'(swap_req), 1);
    sr_cycles = 1;
    tick(); sr_cycles += int'(swap_req);
    tick(); sr_cycles += int'(swap_req);
    swap_ack = 1'b1;
    tick();
    swap_ack = 1'b0;
    check_eq("t1_swap_req_cycles", 32'(sr_cycles), 3);
    check_eq("t1_swap_req_fall", 32'(swap_req), 0);
    check_eq("t1_clear_start", 32'(clear_start), 1);
    check_eq("t1_frame_count", 32'(frame_count), 1);
    clear_busy = 1'b1;
    tick();
    check_eq("t1_clear_start_once", 32'(clear_start), 0);

    // 2: clear busy for 10 cycles, then 5 sprites and queue drains
    repeat (9) tick();
    check_eq("t2_no_draw_while_clear", 32'(draw_en), 0);
    clear_busy = 1'b0;
    tick();
    check_eq("t2_draw_after_clear", 32'(draw_en), 1);
    driver_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sprite_done = 1'b1;
      tick();
      sprite_done = 1'b0;
      tick();
    end
    check_eq("t2_still_drawing", 32'(draw_en), 1);
    queue_empty = 1'b1;
    driver_busy = 1'b0;
    tick();
    check_eq("t2_draw_en_fall", 32'(draw_en), 0);
    check_eq("t2_sprites_drawn", 32'(sprites_drawn), 5);
    check_eq("t2_overrun", 32'(overrun), 0);
    tick();
    check_eq("t2_done_no_swap", 32'(swap_req), 0);

    // 3: clear_busy never rises; DRAW exactly 16 cycles after clear_start
    queue_empty = 1'b0;
    start_frame(2, n);
    check_eq("t3_timeout_cycles", 32'(n), 16);

    // 4: queue never empties, 64 sprites hit the cap
    driver_busy = 1'b1;
    en_cycles = 0;
    for (int i = 0; i < 64; i++) begin
      sprite_done = 1'b1;
      tick();
      en_cycles += int'(draw_en);
    end
    sprite_done = 1'b0;
    check_eq("t4_draw_en_cycles", 32'(en_cycles), 63);
    check_eq("t4_draw_en_fall", 32'(draw_en), 0);
    check_eq("t4_sprites_drawn", 32'(sprites_drawn), 64);
    check_eq("t4_overrun", 32'(overrun), 0);

    // 5: overrun in DRAW, drain with one late sprite
    driver_busy = 1'b0;
    start_frame(3, n);
    driver_busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sprite_done = 1'b1;
      tick();
      sprite_done = 1'b0;
      tick();
    end
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    check_eq("t5_overrun", 32'(overrun), 1);
    check_eq("t5_overrun_count", 32'(overrun_count), 1);
    check_eq("t5_draw_en_drop", 32'(draw_en), 0);
    tick();
    sprite_done = 1'b1;
    tick();
    sprite_done = 1'b0;
    tick();
    tick();
    check_eq("t5_drain_holds", 32'(swap_req), 0);
    driver_busy = 1'b0;
    tick();
    check_eq("t5_swap_after_drain", 32'(swap_req), 1);
    check_eq("t5_sprites_drawn", 32'(sprites_drawn), 3);
    swap_ack = 1'b1;
    tick();
    swap_ack = 1'b0;
    check_eq("t5_frame_count", 32'(frame_count), 4);
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    check_eq("t5_overrun_in_clear", 32'(overrun_count), 2);
    wait_draw(n);

    // 6: frame edge coincides with the drain condition, then reset mid-SWAP
    driver_busy = 1'b1;
    tick();
    queue_empty = 1'b1;
    driver_busy = 1'b0;
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    check_eq("t6_direct_swap", 32'(swap_req), 1);
    check_eq("t6_draw_en", 32'(draw_en), 0);
    check_eq("t6_no_overrun", 32'(overrun_count), 2);
    check_eq("t6_sprites_drawn", 32'(sprites_drawn), 0);
    check_eq("t6_frame_count", 32'(frame_count), 4);
    reset_n = 1'b0;
    #1;
    check_eq("t6_rst_swap_req", 32'(swap_req), 0);
    check_eq("t6_rst_frame_count", 32'(frame_count), 0);
    check_eq("t6_rst_overrun", 32'(overrun), 0);
    check_eq("t6_rst_overrun_count", 32'(overrun_count), 0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
